conv_row_window_feeder: RTL and testbench

- Upstream neighbour of the 28→24 5x5 sliding convolution stage.
- Accepts a 28x28 image one 28-pixel row per handshake and keeps a 5-row sliding window.
- Presents each 1260-bit window with a one-cycle start pulse, then waits for the conv stage's done flag before sliding one row down.
- Issues 24 windows per frame, then pulses frame_done.

---
 rtl/conv_row_window_feeder.sv | 134 +++++++++++++
 tb/tb_conv_row_window_feeder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_row_window_feeder.sv
// conv_row_window_feeder: 5-row sliding window feeder for the 28->24 5x5 conv stage.
// Ports: clk; reset (async, active-low); row_valid/row_ready/row_in (one 28-pixel row per
// handshake, pixel 0 at MSB); win_start (one-cycle pulse, win_out valid); win_out (5 rows,
// oldest at MSB); conv_done (conv stage finished current window); win_idx (window index);
// frame_done (one-cycle pulse after the last window of a frame completes).
// Optional macro CONV_ROW_PREFETCH_EN adds a 1-row staging register filled during WAIT.
module conv_row_window_feeder #(
    parameter int PIX_W = 9,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     row_valid,
    output logic                     row_ready,
    input  logic [IMG_W*PIX_W-1:0]   row_in,
    output logic                     win_start,
    output logic [K*IMG_W*PIX_W-1:0] win_out,
    input  logic                     conv_done,
    output logic [4:0]               win_idx,
    output logic                     frame_done
);
    localparam int RW = IMG_W * PIX_W;
    localparam int WW = K * RW;
    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0] ROWS_LAST = CW'(K - 1);
    localparam logic [4:0] LAST_WIN = 5'(IMG_H - K);
    typedef enum logic [1:0] {FILL, ISSUE, WAIT} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] rows_loaded_q, rows_loaded_d;
    logic [4:0]    win_idx_q, win_idx_d;
    logic [WW-1:0] win_q, win_d;
    logic          frame_done_q, frame_done_d;
    logic          accept;
`ifdef CONV_ROW_PREFETCH_EN
    localparam logic [CW-1:0] ROWS_FULL = CW'(K);
    logic [RW-1:0] stg_q, stg_d, next_row;
    logic          stg_full_q, stg_full_d, have_row;
    // a row arriving in the same cycle as conv_done counts as already staged
    assign have_row  = stg_full_q || accept;
    assign next_row  = stg_full_q ? stg_q : row_in;
    assign row_ready = reset && (state_q == FILL || (state_q == WAIT && !stg_full_q));
`else
    assign row_ready = reset && state_q == FILL;
`endif
    assign accept     = row_valid && row_ready;
    assign win_start  = state_q == ISSUE;
    assign win_out    = win_q;
    assign win_idx    = win_idx_q;
    assign frame_done = frame_done_q;
    always_comb begin
        state_d       = state_q;
        rows_loaded_d = rows_loaded_q;
        win_idx_d     = win_idx_q;
        win_d         = win_q;
        frame_done_d  = 1'b0;
`ifdef CONV_ROW_PREFETCH_EN
        stg_d         = stg_q;
        stg_full_d    = stg_full_q;
`endif
        case (state_q)
            FILL: begin
                if (accept) begin
                    win_d         = {win_q[WW-RW-1:0], row_in};
                    rows_loaded_d = rows_loaded_q + CW'(1);
                    if (rows_loaded_q == ROWS_LAST) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
`ifdef CONV_ROW_PREFETCH_EN
                if (conv_done) begin
                    stg_full_d = 1'b0;
                    if (have_row) begin
                        win_d = {win_q[WW-RW-1:0], next_row};
                    end
                    if (win_idx_q == LAST_WIN) begin
                        frame_done_d  = 1'b1;
                        win_idx_d     = '0;
                        rows_loaded_d = have_row ? CW'(1) : '0;
                        state_d       = FILL;
                    end else begin
                        win_idx_d     = win_idx_q + 5'd1;
                        rows_loaded_d = have_row ? ROWS_FULL : ROWS_LAST;
                        state_d       = have_row ? ISSUE : FILL;
                    end
                end else if (accept) begin
                    stg_d      = row_in;
                    stg_full_d = 1'b1;
                end
`else
                if (conv_done) begin
                    state_d = FILL;
                    if (win_idx_q == LAST_WIN) begin
                        frame_done_d  = 1'b1;
                        win_idx_d     = '0;
                        rows_loaded_d = '0;
                    end else begin
                        win_idx_d     = win_idx_q + 5'd1;
                        rows_loaded_d = ROWS_LAST;
                    end
                end
`endif
            end
            default: state_d = FILL;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= FILL;
            rows_loaded_q <= '0;
            win_idx_q     <= '0;
            win_q         <= '0;
            frame_done_q  <= 1'b0;
`ifdef CONV_ROW_PREFETCH_EN
            stg_q         <= '0;
            stg_full_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rows_loaded_q <= rows_loaded_d;
            win_idx_q     <= win_idx_d;
            win_q         <= win_d;
            frame_done_q  <= frame_done_d;
`ifdef CONV_ROW_PREFETCH_EN
            stg_q         <= stg_d;
            stg_full_q    <= stg_full_d;
`endif
        end
    end
endmodule

// File: tb/tb_conv_row_window_feeder.sv
// tb_conv_row_window_feeder: randomized scoreboard bench for conv_row_window_feeder.
module tb_conv_row_window_feeder;
    localparam int PIX_W = 9;
    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K = 5;
    localparam int RW = IMG_W * PIX_W;
    localparam int WW = K * RW;
    localparam int NWIN = IMG_H - K + 1;
`ifdef CONV_ROW_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic row_valid = 1'b0;
    logic conv_done = 1'b0;
    logic [RW-1:0] row_in = '0;
    logic row_ready, win_start, frame_done;
    logic [WW-1:0] win_out;
    logic [4:0] win_idx;
    logic [WW-1:0] q_win[$];
    int q_idx[$];
    int done_dly = 3;
    int spur_cnt = 0;
    bit end_req = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    int n_fd = 0;
    int n_start = 0;

    conv_row_window_feeder #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
        .clk(clk), .reset(reset), .row_valid(row_valid), .row_ready(row_ready),
        .row_in(row_in), .win_start(win_start), .win_out(win_out), .conv_done(conv_done),
        .win_idx(win_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] det_row(input int r);
        logic [RW-1:0] v;
        v = '0;
        for (int c = 0; c < IMG_W; c++) v[RW-1-c*PIX_W -: PIX_W] = PIX_W'((r * IMG_W + c) % 512);
        return v;
    endfunction

    function automatic logic [RW-1:0] rnd_row();
        logic [RW-1:0] v;
        v = '0;
        for (int c = 0; c < IMG_W; c++) v[RW-1-c*PIX_W -: PIX_W] = PIX_W'($urandom);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_win(input string name, input logic [WW-1:0] exp);
        n_cmp++;
        if (win_out !== exp) begin
            n_err++;
            $display("FAIL %s: win_out top pix %0d (exp %0d), bottom pix %0d (exp %0d), %0d bits differ at %0t",
                     name, win_out[WW-1 -: PIX_W], exp[WW-1 -: PIX_W], win_out[PIX_W-1:0],
                     exp[PIX_W-1:0], $countones(win_out ^ exp), $time);
        end
    endtask

    // vmode: 0 continuous valid, 1 valid toggles every cycle, 2 random idle gaps
    task automatic feed_row(input logic [RW-1:0] r, input int vmode);
        int t;
        if (vmode == 2) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        row_in = r;
        row_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!row_ready && t < 400);
        if (!row_ready) begin
            $display("FAIL feed_row: row_ready never asserted within %0d cycles", t);
            $fatal(1, "feed stalled");
        end
        @(posedge clk);
        #1;
        if (vmode != 0) begin
            row_valid = 1'b0;
            row_in = rnd_row();
            if (vmode == 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run_frame(input bit det, input int vmode, input int stop_win, input int dly, input bit spur);
        logic [RW-1:0] rows[IMG_H];
        logic [WW-1:0] w;
        int t;
        done_dly = dly;
        for (int r = 0; r < IMG_H; r++) rows[r] = det ? det_row(r) : rnd_row();
        for (int k = 0; k < NWIN; k++) begin
            w = '0;
            for (int j = 0; j < K; j++) w = {w[WW-RW-1:0], rows[k+j]};
            q_win.push_back(w);
            q_idx.push_back(k);
        end
        for (int r = 0; r < IMG_H; r++) begin
            feed_row(rows[r], vmode);
            if (spur && r == 1) spur_cnt++;
            if (stop_win >= 0 && r == stop_win + K - 1) begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!win_start && t < 100);
                if (!win_start) begin
                    $display("FAIL reset_window: win_start for window %0d never seen", stop_win);
                    $fatal(1, "window wait expired");
                end
                @(posedge clk);
                #3 reset = 1'b0;
                row_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1 reset = 1'b1;
                return;
            end
        end
    endtask

    // conv stage stand-in: pulses conv_done done_dly cycles after win_start, or on request
    initial begin
        int seen;
        seen = 0;
        forever begin
            @(negedge clk);
            if (spur_cnt != seen) begin
                seen = spur_cnt;
                @(posedge clk);
                #1 conv_done = 1'b1;
                @(posedge clk);
                #1 conv_done = 1'b0;
            end else if (reset && win_start) begin
                repeat (done_dly) @(posedge clk);
                #1 conv_done = 1'b1;
                @(posedge clk);
                #1 conv_done = 1'b0;
            end
        end
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        run_frame(1'b1, 0, -1, 3, 1'b0);
        run_frame(1'b0, 1, -1, $urandom_range(1, 6), 1'b1);
        run_frame(1'b0, 0, -1, 12, 1'b0);
        run_frame(1'b0, 0, 7, 8, 1'b0);
        run_frame(1'b0, 2, -1, $urandom_range(1, 12), 1'b0);
        run_frame(1'b1, 1, -1, 3, 1'b0);
        row_valid = 1'b0;
        t = 0;
        while ((n_fd < 5 || q_win.size() != 0) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        end_req = 1'b1;
    end

    // monitor + reference model: window w of a frame may issue once rows 0..w+K-1 have
    // been accepted and window w-1 has been completed by conv_done
    initial begin
        int acc, nw, dcnt, ei;
        bit busy, exp_start, exp_fd, exp_ready, acc_in, st, f;
        logic [WW-1:0] cur_win, ew;
        acc = 0; nw = 0; dcnt = 0; busy = 0; exp_start = 0; exp_fd = 0; cur_win = '0;
        while (!end_req) begin
            @(negedge clk or negedge reset);
            if (clk || !reset) begin
                acc = 0; nw = 0; dcnt = 0; busy = 0; exp_start = 0; exp_fd = 0;
                q_win.delete();
                q_idx.delete();
                if (clk) #1;
                chk("reset row_ready", 64'(row_ready), 64'(0));
                chk("reset win_start", 64'(win_start), 64'(0));
                chk("reset frame_done", 64'(frame_done), 64'(0));
                chk("reset win_idx", 64'(win_idx), 64'(0));
                chk_win("reset win_out", '0);
            end else begin
                exp_ready = !busy || (PF && !exp_start && acc < nw + K);
                chk("row_ready", 64'(row_ready), 64'(exp_ready));
                chk("win_start", 64'(win_start), 64'(exp_start));
                chk("frame_done", 64'(frame_done), 64'(exp_fd));
                chk("win_idx", 64'(win_idx), 64'(dcnt));
                n_start += int'(win_start);
                n_fd += int'(frame_done);
                if (win_start) begin
                    if (q_win.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL win_start: window issued with none expected at %0t", $time);
                    end else begin
                        ew = q_win.pop_front();
                        ei = q_idx.pop_front();
                        chk_win("window", ew);
                        chk("win_idx at start", 64'(win_idx), 64'(ei));
                        cur_win = ew;
                    end
                end else if (busy) begin
                    chk_win("window hold", cur_win);
                end
                acc_in = row_valid && exp_ready;
                st = 0;
                f = 0;
                if (acc_in) acc++;
                if (!busy) begin
                    st = (acc == nw + K);
                end else if (!exp_start && conv_done) begin
                    busy = 0;
                    if (nw == NWIN) begin
                        f = 1;
                        nw = 0;
                        dcnt = 0;
                        acc -= IMG_H;
                    end else begin
                        dcnt++;
                        st = (acc == nw + K);
                    end
                end
                if (st) begin
                    busy = 1;
                    nw++;
                end
                exp_start = st;
                exp_fd = f;
            end
        end
        chk("frame_done count", 64'(n_fd), 64'(5));
        chk("win_start count", 64'(n_start), 64'(NWIN * 5 + 8));
        chk("windows left in queue", 64'(q_win.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
